// File: rtl/conv2_buf_3ch.sv
// conv2_buf_3ch
// Builds 3x3 windows for the layer-2 convolution from three parallel
// raster-order streams of signed DATA_W-bit pixels. The same window bus
// feeds every output-channel sum calculator. There is no backpressure.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   valid_in       pixel strobe; data_in1..3 sampled when high
//   data_in1..3    channel pixels
//   win1..3        registered 3x3 windows; tap k at [DATA_W*k +: DATA_W],
//                  tap 0 = top-left, tap 8 = newest pixel
//   valid_out_buf  one-cycle strobe; win1..3 hold a new window
//   frame_done     one-cycle strobe after the last pixel of a frame
module conv2_buf_3ch #(
    parameter int WIDTH  = 12,
    parameter int HEIGHT = 12,
    parameter int DATA_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     data_in1,
    input  logic [DATA_W-1:0]     data_in2,
    input  logic [DATA_W-1:0]     data_in3,
    output logic [9*DATA_W-1:0]   win1,
    output logic [9*DATA_W-1:0]   win2,
    output logic [9*DATA_W-1:0]   win3,
    output logic                  valid_out_buf,
    output logic                  frame_done
);

    // The deepest tap is sr[2*WIDTH+1], so nothing beyond it is kept.
    localparam int SR_LEN = 2 * WIDTH + 2;
    localparam int CW     = $clog2(WIDTH);
    localparam int RW     = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    // Index 0 = newest pixel.
    logic [SR_LEN-1:0][DATA_W-1:0] sr1;
    logic [SR_LEN-1:0][DATA_W-1:0] sr2;
    logic [SR_LEN-1:0][DATA_W-1:0] sr3;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          win_fire;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

    // Only pixels at row>=2, col>=2 complete a window lying inside one row
    // band and one frame, so stale or wrapped data is never emitted.
    assign win_fire = valid_in && (row >= RW'(2)) && (col >= CW'(2));

    // Taps are taken from the register contents before this cycle's shift.
    function automatic logic [9*DATA_W-1:0] pack_win(
        input logic [SR_LEN-1:0][DATA_W-1:0] sr,
        input logic [DATA_W-1:0]             px
    );
        pack_win = {px,            sr[0],       sr[1],
                    sr[WIDTH-1],   sr[WIDTH],   sr[WIDTH+1],
                    sr[2*WIDTH-1], sr[2*WIDTH], sr[2*WIDTH+1]};
    endfunction

    // Line storage carries no reset; row/col restarting at 0 keeps old
    // contents from ever reaching a window.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            sr1 <= {sr1[SR_LEN-2:0], data_in1};
            sr2 <= {sr2[SR_LEN-2:0], data_in2};
            sr3 <= {sr3[SR_LEN-2:0], data_in3};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col           <= '0;
            row           <= '0;
            win1          <= '0;
            win2          <= '0;
            win3          <= '0;
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= win_fire;
            frame_done    <= valid_in && row_last && col_last;
            if (win_fire) begin
                win1 <= pack_win(sr1, data_in1);
                win2 <= pack_win(sr2, data_in2);
                win3 <= pack_win(sr3, data_in3);
            end
            if (valid_in) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2_buf_3ch.sv
// Bench for conv2_buf_3ch: a 12x12 instance driven from a pixel-level image
// model with a window scoreboard, plus a 3x3 instance for the minimum size.
module tb_conv2_buf_3ch;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int DW = 12;
    localparam int WW = 9 * DW;
    localparam int VW = 3 * WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [WW-1:0] win1, win2, win3;
    logic          vob, fd;

    logic          vs = 1'b0;
    logic [DW-1:0] s1 = '0, s2 = '0, s3 = '0;
    logic [WW-1:0] sw1, sw2, sw3;
    logic          svob, sfd;

    conv2_buf_3ch #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in1(d1), .data_in2(d2), .data_in3(d3),
        .win1(win1), .win2(win2), .win3(win3),
        .valid_out_buf(vob), .frame_done(fd)
    );

    conv2_buf_3ch #(.WIDTH(3), .HEIGHT(3), .DATA_W(DW)) dut_s (
        .clk(clk), .rst_n(rst_n), .valid_in(vs),
        .data_in1(s1), .data_in2(s2), .data_in3(s3),
        .win1(sw1), .win2(sw2), .win3(sw3),
        .valid_out_buf(svob), .frame_done(sfd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] tap(input logic [VW-1:0] v, input int ch, input int k);
        tap = v[(3-ch)*WW + k*DW +: DW];
    endfunction

    typedef struct {
        logic [VW-1:0] w;
        logic          fd;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [VW-1:0] obs_q[$];
    logic [VW-1:0] ref_q[$];
    logic [VW-1:0] last_w = '0;
    int            fd_cnt = 0;

    logic [DW-1:0] img1 [H][W];
    logic [DW-1:0] img2 [H][W];
    logic [DW-1:0] img3 [H][W];
    int            mr = 0;
    int            mc = 0;

    // Main-instance monitor: scoreboard compare, latency, hold between strobes.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            check("missed_strobe", VW'(cyc), VW'(sb_q[0].cyc));
            void'(sb_q.pop_front());
        end
        if (vob) begin
            check("strobe_expected", VW'(sb_q.size() != 0), VW'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("window", {win1, win2, win3}, e.w);
                check("fd_with_strobe", VW'(fd), VW'(e.fd));
                check("latency", VW'(cyc), VW'(e.cyc));
            end
            obs_q.push_back({win1, win2, win3});
        end else if (rst_q) begin
            check("hold", {win1, win2, win3}, last_w);
        end
        if (fd) fd_cnt++;
        last_w = {win1, win2, win3};
    end

    int            s_cnt = 0;
    int            s_fd_cnt = 0;
    int            s_cyc = 0;
    logic          s_fd = 1'b0;
    logic [VW-1:0] s_win = '0;

    always @(negedge clk) begin
        if (svob) begin
            s_cnt++;
            s_win = {sw1, sw2, sw3};
            s_fd  = sfd;
            s_cyc = cyc;
        end
        if (sfd) s_fd_cnt++;
    end

    task automatic drive(input logic v, input logic [DW-1:0] p1);
        logic [DW-1:0] p2, p3;
        logic [WW-1:0] e1, e2, e3;
        exp_t e;
        p2 = -p1;
        p3 = p1 + 12'h100;
        @(negedge clk);
        valid_in = v;
        d1 = p1;
        d2 = p2;
        d3 = p3;
        if (v) begin
            img1[mr][mc] = p1;
            img2[mr][mc] = p2;
            img3[mr][mc] = p3;
            if (mr >= 2 && mc >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    e1[k*DW +: DW] = img1[mr-2+k/3][mc-2+k%3];
                    e2[k*DW +: DW] = img2[mr-2+k/3][mc-2+k%3];
                    e3[k*DW +: DW] = img3[mr-2+k/3][mc-2+k%3];
                end
                e.w   = {e1, e2, e3};
                e.fd  = (mr == H-1) && (mc == W-1);
                e.cyc = cyc + 1;
                sb_q.push_back(e);
            end
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] base, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                drive(1'b1, base + DW'(r*16 + c));
                if (gaps) drive(1'b0, '0);
            end
    endtask

    task automatic drain();
        repeat (4) drive(1'b0, '0);
        check("queue_drained", VW'(sb_q.size()), VW'(0));
    endtask

    task automatic start_test();
        obs_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] min1;
        logic [VW-1:0] se;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_win", {win1, win2, win3}, '0);
        check("rst_vob_fd", VW'({vob, fd}), VW'(0));
        check("rst_small", {sw1, sw2, sw3, svob, sfd} != 0 ? VW'(1) : VW'(0), VW'(0));
        rst_n = 1'b1;

        // Continuous single frame
        start_test();
        run_frame('0, 1'b0);
        drain();
        check("t1_count", VW'(obs_q.size()), VW'(100));
        if (obs_q.size() == 100) begin
            check("t1_first_c1_t0", VW'(tap(obs_q[0], 1, 0)), VW'(12'h000));
            check("t1_first_c1_t1", VW'(tap(obs_q[0], 1, 1)), VW'(12'h001));
            check("t1_first_c1_t2", VW'(tap(obs_q[0], 1, 2)), VW'(12'h002));
            check("t1_first_c1_t3", VW'(tap(obs_q[0], 1, 3)), VW'(12'h010));
            check("t1_first_c1_t4", VW'(tap(obs_q[0], 1, 4)), VW'(12'h011));
            check("t1_first_c1_t8", VW'(tap(obs_q[0], 1, 8)), VW'(12'h022));
            check("t1_first_c2_t8", VW'(tap(obs_q[0], 2, 8)), VW'(12'hFDE));
            check("t1_first_c3_t4", VW'(tap(obs_q[0], 3, 4)), VW'(12'h111));
            check("t1_last_c1_t0",  VW'(tap(obs_q[99], 1, 0)), VW'(12'h099));
            check("t1_last_c1_t8",  VW'(tap(obs_q[99], 1, 8)), VW'(12'h0BB));
        end
        check("t1_fd_count", VW'(fd_cnt), VW'(1));
        ref_q = obs_q;

        // valid_in toggling every cycle
        start_test();
        run_frame('0, 1'b1);
        drain();
        check("t2_count", VW'(obs_q.size()), VW'(100));
        if (obs_q.size() == 100 && ref_q.size() == 100)
            for (int i = 0; i < 100; i++) check("t2_same_as_t1", obs_q[i], ref_q[i]);
        check("t2_fd_count", VW'(fd_cnt), VW'(1));

        // Back-to-back frames
        start_test();
        run_frame('0, 1'b0);
        run_frame(12'h800, 1'b0);
        drain();
        check("t3_count", VW'(obs_q.size()), VW'(200));
        check("t3_fd_count", VW'(fd_cnt), VW'(2));
        if (obs_q.size() == 200) begin
            check("t3_f2_first_t0", VW'(tap(obs_q[100], 1, 0)), VW'(12'h800));
            check("t3_f2_first_t8", VW'(tap(obs_q[100], 1, 8)), VW'(12'h822));
            min1 = 12'hFFF;
            for (int i = 100; i < 200; i++)
                for (int k = 0; k < 9; k++)
                    if (tap(obs_q[i], 1, k) < min1) min1 = tap(obs_q[i], 1, k);
            check("t3_f2_min_ge_800", VW'(min1 >= 12'h800), VW'(1));
        end

        // Reset after 50 accepted pixels
        start_test();
        for (int i = 0; i < 50; i++) drive(1'b1, DW'((i / W) * 16 + (i % W)));
        @(negedge clk);
        rst_n = 1'b0;
        valid_in = 1'b1;
        d1 = 12'h7FF; d2 = 12'h7FF; d3 = 12'h7FF;
        mr = 0;
        mc = 0;
        sb_q.delete();
        @(negedge clk);
        check("t4_rst_win", {win1, win2, win3}, '0);
        check("t4_rst_vob", VW'(vob), VW'(0));
        check("t4_rst_fd", VW'(fd), VW'(0));
        rst_n = 1'b1;
        valid_in = 1'b0;
        obs_q.delete();
        fd_cnt = 0;
        run_frame('0, 1'b0);
        drain();
        check("t4_count", VW'(obs_q.size()), VW'(100));
        if (obs_q.size() > 0) check("t4_first_t0", VW'(tap(obs_q[0], 1, 0)), VW'(12'h000));
        check("t4_fd_count", VW'(fd_cnt), VW'(1));

        // Minimum size, 3x3
        s_cnt = 0;
        s_fd_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            vs = 1'b1;
            s1 = DW'(i);
            s2 = -DW'(i);
            s3 = DW'(i) + 12'h100;
            se[2*WW + (i-1)*DW +: DW] = DW'(i);
            se[WW + (i-1)*DW +: DW]   = -DW'(i);
            se[(i-1)*DW +: DW]        = DW'(i) + 12'h100;
        end
        @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_count", VW'(s_cnt), VW'(1));
        check("t5_window", s_win, se);
        check("t5_fd_at_strobe", VW'(s_fd), VW'(1));
        check("t5_fd_count", VW'(s_fd_cnt), VW'(1));
        check("t5_latency", VW'(s_cyc), VW'(cyc - 4));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
